// File: rtl/xor_checksum_checker_if.sv
// rtl/xor_checksum_checker_if.sv - stream and status bundle for the XOR checksum checker
//
// Purpose: groups the word stream (valid/ready/data/last), the packet abort
// strobe and the per-packet result/status outputs of xor_checksum_checker.
//
// Signals:
//   in_valid   - upstream word present
//   in_ready   - checker can accept a word this cycle
//   in_data    - data word, or expected checksum when in_last=1
//   in_last    - current word is the packet's checksum word
//   abort      - synchronous packet discard
//   done       - one-cycle pulse, result outputs valid
//   match      - accumulator equalled checksum (valid while done=1)
//   word_count - data words in the packet, checksum word excluded
//   count_ovf  - packet held more data words than word_count can express
//   err_count  - saturating mismatch count since reset
//
// Modports: master = upstream/status consumer side, slave = checker side.

interface xor_checksum_checker_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             abort;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] word_count;
  logic             count_ovf;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output abort,
    input  in_ready,
    input  done,
    input  match,
    input  word_count,
    input  count_ovf,
    input  err_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  abort,
    output in_ready,
    output done,
    output match,
    output word_count,
    output count_ovf,
    output err_count
  );

endinterface

// File: rtl/xor_checksum_checker.sv
// rtl/xor_checksum_checker.sv - receive-side XOR checksum checker with mismatch counter
//
// Purpose: folds every accepted data word into a running XOR accumulator;
// the word flagged in_last carries the expected checksum and is compared
// against the accumulator. The verdict is reported for one cycle (done) and
// mismatches are counted in a saturating err_count.
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-high; clears all state
//   bus   - xor_checksum_checker_if.slave (stream in, result/status out)
//
// FSM: IDLE -> ACCUM on the first data word, IDLE/ACCUM -> REPORT on the
// checksum word, REPORT -> IDLE after exactly one cycle. abort returns
// IDLE/ACCUM to IDLE and is ignored in REPORT.

module xor_checksum_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  xor_checksum_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           r_state;
  state_t           w_next_state;

  logic             w_in_ready;
  logic             w_done;
  logic             w_accept;
  logic             w_accept_data;
  logic             w_accept_last;
  logic             w_mismatch;

  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             r_match;
  logic [CNT_W-1:0] r_word_count;
  logic             r_count_ovf;
  logic [ERR_W-1:0] r_err_count;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.abort) begin
          w_next_state = S_IDLE;
        end else if (w_accept_last) begin
          w_next_state = S_REPORT;
        end else if (w_accept_data) begin
          w_next_state = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.abort) begin
          w_next_state = S_IDLE;
        end else if (w_accept_last) begin
          w_next_state = S_REPORT;
        end
      end
      S_REPORT: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // abort gates in_ready so a word presented alongside abort is never taken.
  always_comb begin
    w_in_ready = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        w_in_ready = ~bus.abort;
      end
      S_REPORT: begin
        w_done = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
        w_done     = 1'b0;
      end
    endcase
  end

  assign w_accept      = bus.in_valid & w_in_ready;
  assign w_accept_data = w_accept & ~bus.in_last;
  assign w_accept_last = w_accept &  bus.in_last;

  // The accumulator is zero in IDLE, so one compare covers both the
  // zero-length packet and the normal end of packet.
  assign w_mismatch = (r_acc != bus.in_data);

  // ---------------------------------------------------------------------------
  // Accumulator, word counter and overflow flag
  // ---------------------------------------------------------------------------
  // Anything that does not lead into ACCUM (abort, checksum word, REPORT,
  // idling) leaves the packet state cleared. Because the accumulator is zero
  // in IDLE, the same XOR/increment path handles the first word of a packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_next_state != S_ACCUM) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept_data) begin
      r_acc <= r_acc ^ bus.in_data;
      // Counter sticks at all-ones; a data word arriving once it is already
      // saturated means the packet has more words than the counter can hold.
      if (r_cnt == CNT_MAX) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered report values and saturating mismatch counter
  // ---------------------------------------------------------------------------
  // Captured on the edge that accepts the checksum word, i.e. the same edge
  // that moves the FSM into REPORT and raises done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match      <= 1'b0;
      r_word_count <= '0;
      r_count_ovf  <= 1'b0;
      r_err_count  <= '0;
    end else if (w_accept_last) begin
      r_match      <= ~w_mismatch;
      r_word_count <= r_cnt;
      r_count_ovf  <= r_ovf;
      if (w_mismatch && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.done       = w_done;
  assign bus.match      = r_match;
  assign bus.word_count = r_word_count;
  assign bus.count_ovf  = r_count_ovf;
  assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_xor_checksum_checker.sv
// tb/tb_xor_checksum_checker.sv - self-checking bench for xor_checksum_checker

module tb_xor_checksum_checker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  xor_checksum_checker_if #(.WIDTH(32), .CNT_W(16), .ERR_W(8)) bus ();
  xor_checksum_checker_if #(.WIDTH(32), .CNT_W(4),  .ERR_W(8)) bus4 ();

  xor_checksum_checker #(.WIDTH(32), .CNT_W(16), .ERR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  xor_checksum_checker #(.WIDTH(32), .CNT_W(4), .ERR_W(8)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    logic        match;
    logic [15:0] wc;
    logic        ovf;
    logic [7:0]  err;
    int          cyc;
  } res_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          stalls   = 0;
  int          last_cyc = 0;
  int          model_err = 0;
  res_t        obs_q[$];
  res_t        exp_q[$];
  logic [31:0] pq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every done pulse is captured with the cycle it appeared in.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      obs_q.push_back('{match: bus.match, wc: bus.word_count, ovf: bus.count_ovf,
                        err: bus.err_count, cyc: cyc});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input bit allow_gap);
    int guard;
    @(negedge clk);
    if (allow_gap && ($urandom_range(0, 3) == 0)) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    #1;
    guard = 0;
    while ((bus.in_ready !== 1'b1) && (guard < 8)) begin
      stalls++;
      guard++;
      @(negedge clk);
      #1;
    end
    if (guard >= 8) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(posedge clk);
    #1;
    if (l) last_cyc = cyc;
  endtask

  // Sends pq as data words followed by chk_word and records the expected report.
  task automatic send_packet(input logic [31:0] chk_word, input bit allow_gap);
    logic [31:0] acc;
    int          n;
    res_t        e;
    acc = 32'h0;
    n   = pq.size();
    foreach (pq[i]) acc = acc ^ pq[i];
    foreach (pq[i]) send_word(pq[i], 1'b0, allow_gap);
    send_word(chk_word, 1'b1, allow_gap);
    e.match = (acc == chk_word);
    e.wc    = (n > 65535) ? 16'hFFFF : 16'(n);
    e.ovf   = (n > 65535);
    if (!e.match && model_err < 255) model_err++;
    e.err   = 8'(model_err);
    e.cyc   = last_cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle_end();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic compare_results(input string tag);
    int n;
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_match"},   64'(obs_q[i].match), 64'(exp_q[i].match));
      chk({tag, "_wc"},      64'(obs_q[i].wc),    64'(exp_q[i].wc));
      chk({tag, "_ovf"},     64'(obs_q[i].ovf),   64'(exp_q[i].ovf));
      chk({tag, "_err"},     64'(obs_q[i].err),   64'(exp_q[i].err));
      chk({tag, "_latency"}, 64'(obs_q[i].cyc),   64'(exp_q[i].cyc));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] acc;
    logic [31:0] w;
    int          len;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.abort     = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_data  = '0;
    bus4.in_last  = 1'b0;
    bus4.abort    = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_match", bus.match, 1'b0);
    chk("rst_wc", bus.word_count, 16'h0);
    chk("rst_ovf", bus.count_ovf, 1'b0);
    chk("rst_err", bus.err_count, 8'h0);
    reset = 1'b0;
    @(negedge clk);

    // Four-word packet, correct checksum
    pq.delete();
    pq.push_back(32'h1); pq.push_back(32'h2); pq.push_back(32'h4); pq.push_back(32'h8);
    send_packet(32'h0000000F, 1'b0);
    idle_end();
    compare_results("pkt4_good");

    // Same words, wrong checksum, then zero-length packet
    send_packet(32'h0000000E, 1'b0);
    idle_end();
    pq.delete();
    send_packet(32'h00000000, 1'b0);
    idle_end();
    compare_results("pkt4_bad_zero_len");
    chk("err_after_bad", bus.err_count, 8'd1);

    // Back-to-back packets, in_valid held high throughout
    stalls = 0;
    pq.delete();
    pq.push_back(32'hDEADBEEF); pq.push_back(32'h12345678); pq.push_back(32'h0F0F0F0F);
    send_packet(32'hDEADBEEF ^ 32'h12345678 ^ 32'h0F0F0F0F, 1'b0);
    pq.delete();
    pq.push_back(32'hCAFEF00D); pq.push_back(32'h00000001);
    send_packet(32'hCAFEF00C, 1'b0);
    idle_end();
    chk("b2b_stall_cycles", 64'(stalls), 64'd1);
    compare_results("b2b");

    // Abort after two data words, with an in_last word presented alongside abort
    send_word(32'h11111111, 1'b0, 1'b0);
    send_word(32'h22222222, 1'b0, 1'b0);
    @(negedge clk);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h33333333;
    bus.in_last  = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    pq.delete();
    pq.push_back(32'hA5A5A5A5); pq.push_back(32'h5A5A5A5A);
    send_packet(32'hFFFFFFFF, 1'b0);
    idle_end();
    compare_results("abort");

    // Randomized packets with valid gaps
    for (int p = 0; p < 40; p++) begin
      pq.delete();
      len = $urandom_range(0, 6);
      acc = 32'h0;
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        pq.push_back(w);
        acc = acc ^ w;
      end
      if ($urandom_range(0, 1) == 1) acc = acc ^ (32'h1 << $urandom_range(0, 31));
      send_packet(acc, 1'b1);
    end
    idle_end();
    compare_results("random");

    // Reset mid-packet
    send_word(32'h01020304, 1'b0, 1'b0);
    send_word(32'h05060708, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    chk("rst_mid_done", bus.done, 1'b0);
    chk("rst_mid_err", bus.err_count, 8'h0);
    model_err = 0;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Reset during REPORT of a mismatching packet: no done is ever sampled
    send_word(32'h0000AAAA, 1'b0, 1'b0);
    send_word(32'h00000001, 1'b1, 1'b0);
    chk("pre_rst_report_done", bus.done, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_report_done", bus.done, 1'b0);
    chk("rst_report_err", bus.err_count, 8'h0);
    chk("rst_report_match", bus.match, 1'b0);
    chk("rst_report_wc", bus.word_count, 16'h0);
    chk("rst_report_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    compare_results("rst_no_stray_done");

    // 256 mismatching zero-length packets saturate err_count
    pq.delete();
    for (int p = 0; p < 256; p++) send_packet(32'h00000001, 1'b0);
    idle_end();
    compare_results("err_sat");
    chk("err_saturated", bus.err_count, 8'd255);

    // CNT_W=4: 17 data words saturate word_count at 15 with count_ovf
    acc = 32'h0;
    for (int i = 0; i < 17; i++) begin
      w = $urandom;
      acc = acc ^ w;
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in_data  = w;
      bus4.in_last  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    bus4.in_data = acc;
    bus4.in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.in_last  = 1'b0;
    chk("cnt4_done", bus4.done, 1'b1);
    chk("cnt4_wc", bus4.word_count, 4'd15);
    chk("cnt4_ovf", bus4.count_ovf, 1'b1);
    chk("cnt4_match", bus4.match, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
